// File: rtl/mmio_peripheral.sv
// MMIO responder beside data memory: timer (TH/TL/TCON), LED, 7-seg and systick registers.
// Reads are combinational from addr; writes land on the rising clock edge.
module mmio_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned LED_W     = 8,
    parameter int unsigned DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              mem_write,
    input  logic              mem_read,
    output logic [31:0]       rdata,
    output logic              sel,
    output logic              irq,
    output logic [LED_W-1:0]  real_led,
    output logic [DIGI_W-1:0] real_digital
);

    localparam logic [2:0] IdxTh      = 3'd0;
    localparam logic [2:0] IdxTl      = 3'd1;
    localparam logic [2:0] IdxTcon    = 3'd2;
    localparam logic [2:0] IdxLed     = 3'd3;
    localparam logic [2:0] IdxDigi    = 3'd4;
    localparam logic [2:0] IdxSystick = 3'd5;

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [2:0]        tcon_q, tcon_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       systick_q, systick_d;

    logic [2:0] idx;
    logic       mapped;
    logic       wr_en;

    assign idx    = addr[4:2];
    assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
    assign mapped = (addr[1:0] == 2'b00) && (idx <= IdxSystick);
    assign wr_en  = mem_write && sel && mapped;

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        // Applied after the timer update so a same-cycle bus write overrides it.
        if (wr_en) begin
            case (idx)
                IdxTh:   th_d   = wdata;
                IdxTl:   tl_d   = wdata;
                IdxTcon: tcon_d = wdata[2:0];
                IdxLed:  led_d  = wdata[LED_W-1:0];
                IdxDigi: digi_d = wdata[DIGI_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (mem_read && sel && mapped) begin
            case (idx)
                IdxTh:      rdata = th_q;
                IdxTl:      rdata = tl_q;
                IdxTcon:    rdata[2:0] = tcon_q;
                IdxLed:     rdata[LED_W-1:0] = led_q;
                IdxDigi:    rdata[DIGI_W-1:0] = digi_q;
                IdxSystick: rdata = systick_q;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    assign irq          = tcon_q[2];
    assign real_led     = led_q;
    assign real_digital = digi_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral: vector table, directed timer/reset sequences,
// and random bus traffic compared against a register-array reference model.
module tb_mmio_peripheral;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE + 32'h00;
    localparam logic [31:0] A_TL = BASE + 32'h04;
    localparam logic [31:0] A_TC = BASE + 32'h08;
    localparam logic [31:0] A_LD = BASE + 32'h0C;
    localparam logic [31:0] A_DG = BASE + 32'h10;
    localparam logic [31:0] A_ST = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        mem_write, mem_read, sel, irq;
    logic [7:0]  real_led;
    logic [11:0] real_digital;

    mmio_peripheral #(
        .BASE_ADDR(BASE),
        .LED_W    (8),
        .DIGI_W   (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .rdata       (rdata),
        .sel         (sel),
        .irq         (irq),
        .real_led    (real_led),
        .real_digital(real_digital)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rdata;

    // Reference model: word-indexed register file TH,TL,TCON,LED,DIGI,SYSTICK.
    logic [31:0] m_reg [6];
    logic [31:0] m_mask[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'hFF, 32'hFFF,
                               32'hFFFF_FFFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_sel(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && (off < 32);
    endfunction

    function automatic logic m_mapped(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return m_sel(a) && (off <= 20) && (off % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
        if (re && m_mapped(a)) return m_reg[(a - BASE) / 4];
        return 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_reg[i] = 32'h0;
    endtask

    task automatic m_clock(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] nx[6];
        int k;
        nx = m_reg;
        nx[5] = m_reg[5] + 1;
        if (m_reg[2][0]) begin
            if (m_reg[1] == 32'hFFFF_FFFF) begin
                nx[1] = m_reg[0];
                if (m_reg[2][1]) nx[2] = m_reg[2] | 32'h4;
            end else begin
                nx[1] = m_reg[1] + 1;
            end
        end
        if (we && m_mapped(a)) begin
            k = int'((a - BASE) / 4);
            if (k < 5) nx[k] = d & m_mask[k];
        end
        m_reg = nx;
    endtask

    // One bus cycle: inputs applied at negedge, combinational outputs checked,
    // then registered outputs checked at the following negedge.
    task automatic step(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d);
        mem_write = we;
        mem_read  = re;
        addr      = a;
        wdata     = d;
        #1;
        last_rdata = rdata;
        check("rdata", rdata, m_read(a, re));
        check("sel", {31'b0, sel}, {31'b0, m_sel(a)});
        @(posedge clk);
        m_clock(we, a, d);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        check("irq", {31'b0, irq}, {31'b0, m_reg[2][2]});
        check("real_led", {24'b0, real_led}, m_reg[3]);
        check("real_digital", {20'b0, real_digital}, m_reg[4]);
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] v;
        logic [31:0] ra;

        vecs[0]  = '{1'b1, 1'b0, A_LD, 32'h0000_01FF, 32'h0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, A_DG, 32'hFFFF_FF7E, 32'h0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, A_LD, 32'h0, 32'h0000_00FF, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, A_DG, 32'h0, 32'h0000_0F7E, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, BASE + 32'h18, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, BASE + 32'h02, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h1000_0000, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, A_TH, 32'h1234_5678, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, A_TH, 32'h0, 32'h1234_5678, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h1000_000C, 32'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, A_LD, 32'h0, 32'h0000_00FF, 1'b1};
        vecs[11] = '{1'b1, 1'b1, A_LD, 32'h0000_00AA, 32'h0000_00FF, 1'b1};
        vecs[12] = '{1'b0, 1'b1, A_LD, 32'h0, 32'h0000_00AA, 1'b1};
        vecs[13] = '{1'b0, 1'b0, A_LD, 32'h0, 32'h0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, A_TC, 32'hFFFF_FFF8, 32'h0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, A_TC, 32'h0, 32'h0, 1'b1};

        reset = 1'b0;
        mem_write = 1'b0;
        mem_read = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_led", {24'b0, real_led}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
        end
        check("digi_trunc", {20'b0, real_digital}, 32'h0000_0F7E);

        // Timer with irq enabled: overflow, reload every 4 cycles, sticky irq
        step(1'b1, 1'b0, A_TH, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, A_TC, 32'h3);
        step(1'b0, 1'b1, A_TL, 32'h0);
        check("t3_tl_fe", last_rdata, 32'hFFFF_FFFE);
        step(1'b0, 1'b1, A_TL, 32'h0);
        check("t3_tl_ff", last_rdata, 32'hFFFF_FFFF);
        check("t3_irq_rise", {31'b0, irq}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, A_TL, 32'h0);
            check("t3_tl_cycle", last_rdata, 32'hFFFF_FFFC + 32'(i % 4));
            check("t3_irq_sticky", {31'b0, irq}, 32'h1);
        end

        // Asynchronous reset mid-count
        step(1'b1, 1'b0, A_LD, 32'h0000_00A5);
        step(1'b0, 1'b0, A_TL, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("t1_led0", {24'b0, real_led}, 32'h0);
        check("t1_digi0", {20'b0, real_digital}, 32'h0);
        check("t1_irq0", {31'b0, irq}, 32'h0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, A_ST, 32'h0);
        check("t1_systick0", last_rdata, 32'h0);
        step(1'b0, 1'b0, A_TL, 32'h0);
        step(1'b0, 1'b1, A_TL, 32'h0);
        check("t1_tl_idle", last_rdata, 32'h0);

        // Timer without irq enable, then enable irq
        step(1'b1, 1'b0, A_TH, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, A_TC, 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, A_TL, 32'h0);
            check("t4_tl_cycle", last_rdata, 32'hFFFF_FFFC + 32'((i + 2) % 4));
            check("t4_irq_low", {31'b0, irq}, 32'h0);
        end
        step(1'b1, 1'b0, A_TC, 32'h3);
        k = 0;
        while (!irq && k < 8) begin
            step(1'b0, 1'b0, A_TL, 32'h0);
            k++;
        end
        check("t4_irq", {31'b0, irq}, 32'h1);
        check("t4_latency", 32'(k), 32'h1);

        // Bus write of TCON on the overflow cycle wins
        step(1'b1, 1'b0, A_TC, 32'h0);
        step(1'b1, 1'b0, A_TL, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, A_TC, 32'h3);
        step(1'b0, 1'b0, A_TL, 32'h0);
        step(1'b1, 1'b0, A_TC, 32'h3);
        check("t5_irq0", {31'b0, irq}, 32'h0);
        step(1'b0, 1'b1, A_TC, 32'h0);
        check("t5_tcon", last_rdata, 32'h3);
        step(1'b0, 1'b1, A_TL, 32'h0);
        check("t5_tl", last_rdata, 32'hFFFF_FFFD);
        // TH written on overflow: reload uses the old TH
        step(1'b0, 1'b0, A_TL, 32'h0);
        step(1'b1, 1'b0, A_TH, 32'h0000_0010);
        step(1'b0, 1'b1, A_TL, 32'h0);
        check("t5_reload_old_th", last_rdata, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, A_TH, 32'h0);
        check("t5_th_new", last_rdata, 32'h0000_0010);

        // SYSTICK is read-only
        step(1'b0, 1'b1, A_ST, 32'h0);
        v = last_rdata;
        step(1'b1, 1'b0, A_ST, 32'h0);
        step(1'b0, 1'b1, A_ST, 32'h0);
        check("t6_systick_ro", last_rdata, v + 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = BASE + 32'h18;
                1:       ra = BASE + 32'h1C;
                2:       ra = BASE + 32'(($urandom_range(0, 5) * 4) + $urandom_range(1, 3));
                3:       ra = 32'h1000_0000 + 32'($urandom_range(0, 31));
                default: ra = BASE + 32'($urandom_range(0, 5) * 4);
            endcase
            v = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), ra, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
